// File: rtl/gcd_pkg.sv
// Shared definitions for the subtraction-based GCD controller: state encoding,
// default operand width and the iteration-counter width helper.
package gcd_pkg;

    localparam int GCD_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_SUB_X,
        S_SUB_Y,
        S_DONE,
        S_ERR
    } gcd_state_t;

    // Bits needed to hold 0..max_iter inclusive; never less than one bit.
    function automatic int cnt_width(input int max_iter);
        return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/gcd_ctrl_if.sv
// Handshake, comparator-flag and datapath-strobe bundle between the GCD
// controller (master) and its X/Y datapath plus requester (slave).
interface gcd_ctrl_if;

    logic start;
    logic eq_in;
    logic lt_in;
    logic gt_in;
    logic ld_x;
    logic ld_y;
    logic sel_x;
    logic sel_y;
    logic busy;
    logic done;
    logic err;

    modport master (
        input  start, eq_in, lt_in, gt_in,
        output ld_x, ld_y, sel_x, sel_y, busy, done, err
    );

    modport slave (
        output start, eq_in, lt_in, gt_in,
        input  ld_x, ld_y, sel_x, sel_y, busy, done, err
    );

endinterface

// File: rtl/gcd_iter_cnt.sv
// Saturating subtract-step counter used as the GCD watchdog; at_limit_o is
// high while the count sits at MAX_ITER.
module gcd_iter_cnt
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = (1 << GCD_WIDTH_DEF) - 1,
    localparam int CW      = cnt_width(MAX_ITER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          at_limit_o
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_ITER);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/gcd_ctrl.sv
// Moore control FSM for the subtraction GCD engine: drives X/Y load/select
// strobes from comparator flags, owns start/done and the iteration watchdog.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH_DEF,
    parameter int MAX_ITER = (1 << WIDTH) - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gcd_ctrl_if.master      bus
);

    localparam int CW = cnt_width(MAX_ITER);

    gcd_state_t    state_q;
    gcd_state_t    state_d;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          at_limit;
    logic [CW-1:0] iter_cnt_unused;
    logic          flags_onehot;

    // Only the limit flag steers the FSM; the raw count is kept for visibility.
    gcd_iter_cnt #(
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .cnt_o      (iter_cnt_unused),
        .at_limit_o (at_limit)
    );

    assign flags_onehot = $onehot({bus.eq_in, bus.lt_in, bus.gt_in});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_CMP;
            S_CMP: begin
                // A corrupt comparator is fatal; the watchdog only beats gt/lt.
                if (!flags_onehot)    state_d = S_ERR;
                else if (bus.eq_in)   state_d = S_DONE;
                else if (at_limit)    state_d = S_ERR;
                else if (bus.gt_in)   state_d = S_SUB_X;
                else                  state_d = S_SUB_Y;
            end
            S_SUB_X, S_SUB_Y: state_d = S_CMP;
            S_DONE, S_ERR:    state_d = S_IDLE;
            default:          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ld_x  = 1'b0;
        bus.ld_y  = 1'b0;
        bus.sel_x = 1'b0;
        bus.sel_y = 1'b0;
        bus.done  = 1'b0;
        bus.err   = 1'b0;
        bus.busy  = (state_q != S_IDLE);
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                bus.ld_x = 1'b1;
                bus.ld_y = 1'b1;
                cnt_clr  = 1'b1;
            end
            S_SUB_X: begin
                bus.ld_x  = 1'b1;
                bus.sel_x = 1'b1;
                cnt_inc   = 1'b1;
            end
            S_SUB_Y: begin
                bus.ld_y  = 1'b1;
                bus.sel_y = 1'b1;
                cnt_inc   = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            S_ERR: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: a behavioural X/Y datapath closes the
// loop, and a Euclid-by-subtraction model predicts steps, timing and result.
module tb_gcd_ctrl;

    localparam int WIDTH    = 8;
    localparam int MAX_ITER = (1 << WIDTH) - 1;
    localparam int LIMIT    = 2 * MAX_ITER + 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gcd_ctrl_if bus ();

    gcd_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] a_op, b_op, x_q, y_q;
    logic frc, f_eq, f_lt, f_gt;

    assign bus.eq_in = frc ? f_eq : (x_q == y_q);
    assign bus.lt_in = frc ? f_lt : (x_q <  y_q);
    assign bus.gt_in = frc ? f_gt : (x_q >  y_q);

    always @(posedge clk) begin
        if (bus.ld_x) x_q <= bus.sel_x ? x_q - y_q : a_op;
        if (bus.ld_y) y_q <= bus.sel_y ? y_q - x_q : b_op;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_seq[$];
    int got_seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.ld_x, bus.ld_y, bus.sel_x, bus.sel_y, bus.busy, bus.done, bus.err};
    endfunction

    function automatic int strobe_code();
        if ( bus.ld_x &&  bus.ld_y && !bus.sel_x && !bus.sel_y) return 0;
        if ( bus.ld_x && !bus.ld_y &&  bus.sel_x && !bus.sel_y) return 1;
        if (!bus.ld_x &&  bus.ld_y && !bus.sel_x &&  bus.sel_y) return 2;
        return 3;
    endfunction

    // Euclid by repeated subtraction, capped at MAX_ITER steps: 0=LOAD, 1=X-=Y, 2=Y-=X.
    task automatic model(input int a, input int b, output int steps, output bit err, output int g);
        exp_seq = {0};
        steps   = 0;
        while (a != b && steps < MAX_ITER) begin
            if (a > b) begin a -= b; exp_seq.push_back(1); end
            else       begin b -= a; exp_seq.push_back(2); end
            steps++;
        end
        err = (a != b);
        g   = a;
    endtask

    task automatic run(input int a, input int b, input int pulse_cyc, input string tag);
        int  steps, g, done_cyc;
        bit  exp_err, busy_ok, seq_ok;
        logic err_seen;
        model(a, b, steps, exp_err, g);
        got_seq.delete();
        done_cyc = -1;
        err_seen = 1'b0;
        busy_ok  = 1'b1;
        @(negedge clk);
        a_op = WIDTH'(a);
        b_op = WIDTH'(b);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= LIMIT; n++) begin
            if (pulse_cyc > 0 && n == pulse_cyc)     bus.start = 1'b1;
            if (pulse_cyc > 0 && n == pulse_cyc + 1) bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.ld_x || bus.ld_y) got_seq.push_back(strobe_code());
            if (bus.done) begin
                done_cyc = n;
                err_seen = bus.err;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, 2 * steps + 3);
        check({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 1);
        if (!exp_err) check({tag, "_result"}, {24'd0, x_q}, g);
        seq_ok = (got_seq.size() == exp_seq.size());
        for (int i = 0; i < exp_seq.size() && seq_ok; i++)
            if (got_seq[i] != exp_seq[i]) seq_ok = 1'b0;
        check({tag, "_strobe_seq"}, {31'd0, seq_ok}, 1);
        @(negedge clk);
        check({tag, "_idle_after"}, {25'd0, outs()}, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        frc  = 1'b0;
        f_eq = 1'b0;
        f_lt = 1'b0;
        f_gt = 1'b0;
        a_op = '0;
        b_op = '0;

        repeat (3) @(negedge clk);
        check("reset_held_outs", {25'd0, outs()}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_outs", {25'd0, outs()}, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 1);
        repeat (4) @(negedge clk);
        check("busy_zero_zero_end", {31'd0, bus.busy}, 0);

        run(12, 8, 0, "op_12_8");
        run(1, 255, 0, "op_1_255");
        run(0, 5, 0, "op_0_5");
        run(0, 0, 0, "op_0_0");
        run(12, 8, 4, "start_midrun");

        // Corrupt comparator flags during CMP.
        @(negedge clk);
        a_op = 8'd12;
        b_op = 8'd8;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("force_in_cmp", {25'd0, outs()}, 7'b0000100);
        frc  = 1'b1;
        f_eq = 1'b1;
        f_lt = 1'b1;
        f_gt = 1'b0;
        @(negedge clk);
        check("force_err_state", {25'd0, outs()}, 7'b0000111);
        frc = 1'b0;
        @(negedge clk);
        check("force_back_idle", {25'd0, outs()}, 0);

        // Reset dropped during SUB_X.
        a_op = 8'd12;
        b_op = 8'd8;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_subx", {25'd0, outs()}, 7'b1010100);
        rst_n = 1'b0;
        #1;
        check("rst_immediate_outs", {25'd0, outs()}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(9, 6, 0, "op_9_6_after_rst");

        for (int i = 0; i < 8; i++) begin
            int ra, rb;
            ra = int'($urandom_range(1, MAX_ITER));
            rb = int'($urandom_range(1, MAX_ITER));
            run(ra, rb, 0, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
